// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states,
// CSR addresses, mstatus bit positions and trap cause codes.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T_EPC,
    ST_T_CAUSE,
    ST_T_STATUS,
    ST_T_JUMP,
    ST_R_STATUS,
    ST_R_JUMP
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [63:0] CAUSE_ECALL_M = 64'h0000_0000_0000_000B;
  localparam logic [63:0] CAUSE_TIMER_M = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap/return sequencer: serialises mepc/mcause/mstatus updates
// through the single CSR file port and redirects the pipeline to mtvec/mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN      = 64,
  parameter logic [XLEN-1:0]  IRQ_CAUSE = 64'h8000_0000_0000_0007
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] inst_pc,
  input  logic            ecall_req,
  input  logic            mret_req,
  input  logic            irq_timer,
  input  logic            csr_inst_wen,
  input  logic [11:0]     csr_inst_waddr,
  input  logic [XLEN-1:0] csr_inst_wdata,
  output logic            csr_inst_ready,
  input  logic [11:0]     csr_inst_raddr,
  output logic [XLEN-1:0] csr_inst_rdata,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_t     state_q, state_d;
  logic [XLEN-1:0] epc_q, cause_q;
  logic            mie_shadow_q;

  logic            irq_take, ecall_take, mret_take;
  logic            idle, pipe_wr;
  logic            ctrl_wen, redir_v;
  logic [11:0]     ctrl_waddr, fsm_raddr;
  logic [XLEN-1:0] ctrl_wdata, redir_pc, status_upd;

  assign idle = (state_q == ST_IDLE);

  always_comb begin
    irq_take   = 1'b0;
    ecall_take = 1'b0;
    mret_take  = 1'b0;
    if (!reset && idle) begin
      irq_take   = commit_valid & irq_timer & mie_shadow_q;
      ecall_take = commit_valid & ecall_req & ~irq_take;
      mret_take  = commit_valid & mret_req & ~irq_take & ~ecall_take;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_wen   = 1'b0;
    ctrl_waddr = '0;
    ctrl_wdata = '0;
    fsm_raddr  = '0;
    redir_v    = 1'b0;
    redir_pc   = '0;
    status_upd = csr_rdata;
    case (state_q)
      ST_IDLE: begin
        if (irq_take || ecall_take) state_d = ST_T_EPC;
        else if (mret_take)         state_d = ST_R_STATUS;
      end
      ST_T_EPC: begin
        ctrl_wen   = 1'b1;
        ctrl_waddr = CSR_MEPC;
        ctrl_wdata = epc_q;
        fsm_raddr  = CSR_MEPC;
        state_d    = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        ctrl_wen   = 1'b1;
        ctrl_waddr = CSR_MCAUSE;
        ctrl_wdata = cause_q;
        fsm_raddr  = CSR_MCAUSE;
        state_d    = ST_T_STATUS;
      end
      ST_T_STATUS: begin
        // read-modify-write within one cycle: the CSR file read is combinational
        status_upd[MSTATUS_MPIE] = csr_rdata[MSTATUS_MIE];
        status_upd[MSTATUS_MIE]  = 1'b0;
        status_upd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        fsm_raddr  = CSR_MSTATUS;
        ctrl_wen   = 1'b1;
        ctrl_waddr = CSR_MSTATUS;
        ctrl_wdata = status_upd;
        state_d    = ST_T_JUMP;
      end
      ST_T_JUMP: begin
        fsm_raddr = CSR_MTVEC;
        redir_v   = 1'b1;
        redir_pc  = {csr_rdata[XLEN-1:2], 2'b00};
        state_d   = ST_IDLE;
      end
      ST_R_STATUS: begin
        status_upd[MSTATUS_MIE]  = csr_rdata[MSTATUS_MPIE];
        status_upd[MSTATUS_MPIE] = 1'b1;
        status_upd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        fsm_raddr  = CSR_MSTATUS;
        ctrl_wen   = 1'b1;
        ctrl_waddr = CSR_MSTATUS;
        ctrl_wdata = status_upd;
        state_d    = ST_R_JUMP;
      end
      ST_R_JUMP: begin
        fsm_raddr = CSR_MEPC;
        redir_v   = 1'b1;
        redir_pc  = csr_rdata;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset forces every externally visible strobe low, even mid-sequence
  always_comb begin
    stall          = !reset & (!idle | irq_take | ecall_take | mret_take);
    csr_inst_ready = !reset & idle & !stall;
    pipe_wr        = csr_inst_ready & csr_inst_wen;
    csr_wen        = !reset & (idle ? pipe_wr : ctrl_wen);
    csr_waddr      = pipe_wr ? csr_inst_waddr : ctrl_waddr;
    csr_wdata      = pipe_wr ? csr_inst_wdata : ctrl_wdata;
    csr_raddr      = idle ? csr_inst_raddr : fsm_raddr;
    csr_inst_rdata = idle ? csr_rdata : '0;
    redirect_valid = !reset & redir_v;
    redirect_pc    = reset ? '0 : redir_pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      mie_shadow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (irq_take || ecall_take) begin
        epc_q   <= inst_pc;
        cause_q <= irq_take ? IRQ_CAUSE : XLEN'(CAUSE_ECALL_M);
      end
      if (csr_wen && csr_waddr == CSR_MSTATUS)
        mie_shadow_q <= csr_wdata[MSTATUS_MIE];
    end
  end

endmodule
